// File: rtl/encr_rx_buf_read_ctrl_pkg.sv
// Shared definitions for the encryption RX buffer read controller.
// The optional WAPI mode is enabled with RW_WAPI_EN.
package encr_rx_buf_read_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPayload = 3'd1,
        StMic     = 3'd2,
        StBlkWait = 3'd3,
        StDone    = 3'd4
    } decrState_e;

    localparam int unsigned MicLenWep  = 4;
    localparam int unsigned MicLenCcmp = 8;
    localparam int unsigned MicLenWapi = 16;
    localparam int unsigned BlockBytes = 16;

    function automatic logic isPopState(decrState_e s);
        return (s == StPayload) || (s == StMic);
    endfunction

endpackage

// File: rtl/encr_rx_buf_read_ctrl_trailer_len.sv
// Trailer length select and length-error compare for one received frame.
// With RW_WAPI_EN, WAPI frames use a 16-byte trailer and block pacing.
module encr_rx_trailer_len
    import encr_rx_buf_read_ctrl_pkg::*;
#(
    parameter int unsigned MICLEN_WEP  = MicLenWep,
    parameter int unsigned MICLEN_CCMP = MicLenCcmp
) (
    input  logic        rxCCMP,
`ifdef RW_WAPI_EN
    input  logic        rxWAPI,
`endif
    input  logic [15:0] rxPayloadLen,
    output logic [15:0] micLen,
    output logic        blockMode,
    output logic        lenErr
);

    always_comb begin
        micLen    = 16'(MICLEN_WEP);
        blockMode = 1'b0;
`ifdef RW_WAPI_EN
        // WAPI takes priority when both mode bits are set.
        if (rxWAPI) begin
            micLen    = 16'(MicLenWapi);
            blockMode = 1'b1;
        end else if (rxCCMP) begin
            micLen    = 16'(MICLEN_CCMP);
            blockMode = 1'b1;
        end
`else
        if (rxCCMP) begin
            micLen    = 16'(MICLEN_CCMP);
            blockMode = 1'b1;
        end
`endif
    end

    assign lenErr = rxPayloadLen < micLen;

endmodule

// File: rtl/encr_rx_buf_read_ctrl.sv
// Pops encrypted MPDU bytes from the RX buffer into the decryption engine, tagging
// payload/trailer bytes and pacing CCMP blocks. RW_WAPI_EN adds the rxWAPI mode input.
module encr_rx_buf_read_ctrl
    import encr_rx_buf_read_ctrl_pkg::*;
#(
    parameter int unsigned MICLEN_WEP  = MicLenWep,
    parameter int unsigned MICLEN_CCMP = MicLenCcmp,
    parameter int unsigned BLOCK_BYTES = BlockBytes
) (
    input  logic        bbClk,
    input  logic        hardRstBbClk_n,
    input  logic        softRstBbClk_p,
    input  logic        rxDecrStart_p,
    input  logic [15:0] rxPayloadLen,
    input  logic        rxCCMP,
`ifdef RW_WAPI_EN
    input  logic        rxWAPI,
`endif
    input  logic        rxAbort_p,
    input  logic        bufferEmptyFlag,
    input  logic        cipherReady,
    input  logic        cipherBlockDone_p,
    output logic        popDataOutBuffer_p,
    output logic        encrRxBufFlush_p,
    output logic        byteValid_p,
    output logic        byteIsMic,
    output logic        lastByte_p,
    output logic        blockLast_p,
    output logic        decrBusy,
    output logic        decrDone_p,
    output logic        decrLenErr_p
);

    decrState_e  state_q, state_d;
    logic [15:0] remCnt_q, remCnt_d;
    logic [15:0] payRem_q, payRem_d;
    logic [4:0]  blkCnt_q, blkCnt_d;
    logic        blockMode_q, blockMode_d;

    logic byteValid_q, byteValid_d;
    logic byteIsMic_q, byteIsMic_d;
    logic lastByte_q, lastByte_d;
    logic blockLast_q, blockLast_d;
    logic flush_q, flush_d;
    logic lenErr_q, lenErr_d;
    logic done_q, done_d;

    logic [15:0] micLen;
    logic        trBlockMode;
    logic        lenErr;
    logic        popOk;
    logic        startOk;
    logic        abortOk;
    logic        blockFull;

    encr_rx_trailer_len #(
        .MICLEN_WEP  (MICLEN_WEP),
        .MICLEN_CCMP (MICLEN_CCMP)
    ) u_trailerLen (
        .rxCCMP       (rxCCMP),
`ifdef RW_WAPI_EN
        .rxWAPI       (rxWAPI),
`endif
        .rxPayloadLen (rxPayloadLen),
        .micLen       (micLen),
        .blockMode    (trBlockMode),
        .lenErr       (lenErr)
    );

    assign abortOk   = rxAbort_p && (state_q != StIdle);
    assign startOk   = rxDecrStart_p && (state_q == StIdle) && !rxAbort_p;
    assign blockFull = blockMode_q && (blkCnt_q == 5'(BLOCK_BYTES - 1));

    // Pop decision uses only registered state and live flags so an empty buffer is never popped.
    assign popOk = isPopState(state_q) && !bufferEmptyFlag && cipherReady &&
                   (remCnt_q != 16'd0) && !rxAbort_p && !softRstBbClk_p;

    always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
        if (!hardRstBbClk_n) begin
            state_q <= StIdle;
        end else if (softRstBbClk_p) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abortOk) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (startOk && !lenErr) begin
                        state_d = (rxPayloadLen == micLen) ? StMic : StPayload;
                    end
                end
                StPayload: begin
                    if (popOk) begin
                        if (payRem_q == 16'd1) begin
                            state_d = StMic;
                        end else if (blockFull) begin
                            state_d = StBlkWait;
                        end
                    end
                end
                StMic: begin
                    if (popOk && (remCnt_q == 16'd1)) begin
                        state_d = StDone;
                    end
                end
                StBlkWait: begin
                    if (cipherBlockDone_p) begin
                        state_d = StPayload;
                    end
                end
                StDone: begin
                    if (byteValid_q && lastByte_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        popDataOutBuffer_p = popOk;
        decrBusy           = (state_q != StIdle);
        byteValid_d        = popOk;
        byteIsMic_d        = popOk && (state_q == StMic);
        lastByte_d         = popOk && (remCnt_q == 16'd1);
        blockLast_d        = popOk && (state_q == StPayload) &&
                             ((payRem_q == 16'd1) || blockFull);
        flush_d            = abortOk || (startOk && lenErr);
        lenErr_d           = startOk && lenErr;
        done_d             = (state_q == StDone) && byteValid_q && lastByte_q && !abortOk;
    end

    always_comb begin
        remCnt_d    = remCnt_q;
        payRem_d    = payRem_q;
        blkCnt_d    = blkCnt_q;
        blockMode_d = blockMode_q;
        if (abortOk) begin
            remCnt_d    = 16'd0;
            payRem_d    = 16'd0;
            blkCnt_d    = 5'd0;
            blockMode_d = 1'b0;
        end else if (startOk) begin
            // Compare happens first, so the subtraction below never wraps.
            remCnt_d    = lenErr ? 16'd0 : rxPayloadLen;
            payRem_d    = lenErr ? 16'd0 : (rxPayloadLen - micLen);
            blkCnt_d    = 5'd0;
            blockMode_d = lenErr ? 1'b0 : trBlockMode;
        end else if (popOk) begin
            remCnt_d = remCnt_q - 16'd1;
            if (state_q == StPayload) begin
                payRem_d = payRem_q - 16'd1;
                if (blockMode_q) begin
                    blkCnt_d = blkCnt_q + 5'd1;
                end
            end
        end else if ((state_q == StBlkWait) && cipherBlockDone_p) begin
            blkCnt_d = 5'd0;
        end
    end

    always_ff @(posedge bbClk or negedge hardRstBbClk_n) begin
        if (!hardRstBbClk_n) begin
            remCnt_q    <= 16'd0;
            payRem_q    <= 16'd0;
            blkCnt_q    <= 5'd0;
            blockMode_q <= 1'b0;
            byteValid_q <= 1'b0;
            byteIsMic_q <= 1'b0;
            lastByte_q  <= 1'b0;
            blockLast_q <= 1'b0;
            flush_q     <= 1'b0;
            lenErr_q    <= 1'b0;
            done_q      <= 1'b0;
        end else if (softRstBbClk_p) begin
            remCnt_q    <= 16'd0;
            payRem_q    <= 16'd0;
            blkCnt_q    <= 5'd0;
            blockMode_q <= 1'b0;
            byteValid_q <= 1'b0;
            byteIsMic_q <= 1'b0;
            lastByte_q  <= 1'b0;
            blockLast_q <= 1'b0;
            flush_q     <= 1'b0;
            lenErr_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            remCnt_q    <= remCnt_d;
            payRem_q    <= payRem_d;
            blkCnt_q    <= blkCnt_d;
            blockMode_q <= blockMode_d;
            byteValid_q <= byteValid_d;
            byteIsMic_q <= byteIsMic_d;
            lastByte_q  <= lastByte_d;
            blockLast_q <= blockLast_d;
            flush_q     <= flush_d;
            lenErr_q    <= lenErr_d;
            done_q      <= done_d;
        end
    end

    assign byteValid_p      = byteValid_q;
    assign byteIsMic        = byteIsMic_q;
    assign lastByte_p       = lastByte_q;
    assign blockLast_p      = blockLast_q;
    assign encrRxBufFlush_p = flush_q;
    assign decrLenErr_p     = lenErr_q;
    assign decrDone_p       = done_q;

endmodule

// File: doc/encr_rx_buf_read_ctrl.md
# encr_rx_buf_read_ctrl

Sequences reads from the encryption RX buffer into the RX decryption engine. Per received MPDU it pops the encrypted body byte by byte and tags each byte as payload or MIC/ICV trailer. In CCMP mode it paces pops in 16-byte AES blocks. It flushes the buffer on abort or error and pulses completion to the RX controller. It sits between the buffer controller (empty/almost-empty flags, pop pulse, flush pulse) and the cipher cores.

## Interface
Parameters:
- MICLEN_WEP, 4: ICV bytes for WEP/TKIP frames.
- MICLEN_CCMP, 8: MIC bytes for CCMP frames.
- BLOCK_BYTES, 16: CCMP block size in bytes.

Ports:
- bbClk  in  1  baseband clock.
- hardRstBbClk_n  in  1  asynchronous active-low reset.
- softRstBbClk_p  in  1  synchronous software reset; same effect as hard reset.
- rxDecrStart_p  in  1  start pulse for one frame; rxPayloadLen and mode inputs are sampled on it.
- rxPayloadLen  in  16  encrypted body length in bytes, trailer included.
- rxCCMP  in  1  CCMP frame.
- rxAbort_p  in  1  abort the current frame.
- bufferEmptyFlag  in  1  encryption RX buffer is empty.
- cipherReady  in  1  engine can accept a byte this cycle.
- cipherBlockDone_p  in  1  engine finished one CCMP block.
- popDataOutBuffer_p  out  1  pop pulse to the buffer.
- encrRxBufFlush_p  out  1  flush pulse to the buffer.
- byteValid_p  out  1  buffer read data is valid this cycle.
- byteIsMic  out  1  qualifies byteValid_p: byte belongs to the trailer.
- lastByte_p  out  1  qualifies byteValid_p: final byte of the frame.
- blockLast_p  out  1  qualifies byteValid_p: 16th byte of a CCMP block, or the last payload byte.
- decrBusy  out  1  state is not IDLE.
- decrDone_p  out  1  frame completed normally.
- decrLenErr_p  out  1  rxPayloadLen is shorter than the trailer.

All outputs reset to 0.

## Operation
- Trailer length micLen:
  - MICLEN_CCMP when rxCCMP.
  - 16 when rxWAPI (RW_WAPI_EN only).
  - MICLEN_WEP otherwise.
- Registers:
  - remCnt (16b): bytes left in the frame.
  - payRem (16b): payload bytes left.
  - blkCnt (5b): pops in the current CCMP block.
  - modeReg: mode sampled at start.
- States:
  - IDLE: on rxDecrStart_p, load remCnt = rxPayloadLen, payRem = rxPayloadLen - micLen, blkCnt = 0. If rxPayloadLen < micLen, pulse decrLenErr_p and encrRxBufFlush_p and stay in IDLE. Else go to PAYLOAD, or to MIC if payRem = 0.
  - PAYLOAD: pop when popOk. Each pop decrements remCnt and payRem. On the pop with payRem = 1, go to MIC.
  - MIC: pop when popOk. Each pop decrements remCnt. On the pop with remCnt = 1, go to DONE.
  - BLKWAIT: entered from PAYLOAD (CCMP only) after the 16th pop of a block with payRem > 0. Wait for cipherBlockDone_p, then clear blkCnt and return to PAYLOAD.
  - DONE: wait for the last byteValid_p, pulse decrDone_p, go to IDLE.
- popOk = state in {PAYLOAD, MIC} && !bufferEmptyFlag && cipherReady && remCnt != 0.
- popDataOutBuffer_p is combinational from registered state and current inputs, so it never pops a buffer already flagged empty.
- Abort: rxAbort_p in any non-IDLE state pulses encrRxBufFlush_p next cycle, suppresses any pop that cycle, clears all counters and returns to IDLE without decrDone_p.
- Precedence: hard reset > softRstBbClk_p > rxAbort_p > rxDecrStart_p. rxDecrStart_p outside IDLE is ignored.
- Arithmetic: 16-bit unsigned. The length-error check is done before the subtraction, so payRem never wraps.

## Timing
- byteValid_p, byteIsMic, lastByte_p and blockLast_p are registered. They assert exactly 1 cycle after the matching pop, aligned with the 1-cycle buffer RAM read latency.
- Sustained rate: 1 byte per cycle while data and cipherReady are present.
- CCMP stall: at least 1 cycle per block (BLKWAIT), plus the engine latency.
- Start to first pop: 1 cycle minimum. The first pop can occur in the cycle after rxDecrStart_p.
- decrDone_p fires in the cycle after the last byteValid_p. decrBusy falls in that same cycle.
- encrRxBufFlush_p is a 1-cycle pulse, 1 cycle after rxAbort_p or after the length-error start.

## Configuration
- RW_WAPI_EN defined:
  - Adds input rxWAPI (1b).
  - WAPI trailer is 16 bytes.
  - WAPI frames also use 16-byte block pacing with BLKWAIT.
  - If rxCCMP and rxWAPI are both set, rxWAPI wins.
- RW_WAPI_EN undefined: no rxWAPI port; only WEP/TKIP and CCMP modes exist.

## Structure
- Shared package/define file holds:
  - State encodings: IDLE=0, PAYLOAD=1, MIC=2, BLKWAIT=3, DONE=4, 3 bits.
  - Trailer-length constants.
  - BLOCK_BYTES.
- Natural sub-module: encr_rx_trailer_len, a combinational micLen select plus length-error compare. Everything else lives in one FSM/counter module.

## Test plan
- WEP, len 20, buffer always non-empty, cipherReady = 1 -> 20 consecutive pops; bytes 1–16 byteIsMic = 0, 17–20 byteIsMic = 1; lastByte_p on byte 20; decrDone_p 1 cycle later.
- CCMP, len 40 -> payload 32 bytes in two blocks with a BLKWAIT stall after pop 16 until cipherBlockDone_p; blockLast_p on bytes 16 and 32; 8 MIC bytes follow.
- Buffer empty toggling every other cycle and cipherReady held low for 5 cycles -> no pop while empty or not ready; total pops exactly equal len.
- rxAbort_p after 7 pops of a 30-byte frame -> no further pops; flush pulse next cycle; decrBusy = 0; no decrDone_p.
- CCMP, len 5 -> decrLenErr_p plus flush; zero pops. CCMP, len 8 -> goes straight to MIC; 8 pops, all byteIsMic = 1.
- With RW_WAPI_EN: rxWAPI and rxCCMP both set, len 48 -> 32 payload bytes with 16-byte block pacing, then 16 MIC bytes.
